// File: rtl/demux_l1_sched_pkg.sv
// Shared types and constants for the two-lane to four-output demux scheduler.
// The destination of a lane depends only on the lane index and the selector bit.
package demux_l1_sched_pkg;

  localparam int DATA_W    = 8;
  localparam int NUM_LANES = 2;
  localparam int NUM_OUTS  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  // lane0 -> output sel ? 1 : 0, lane1 -> output sel ? 3 : 2
  function automatic logic [1:0] dest(input logic lane, input logic sel);
    return {lane, sel};
  endfunction

endpackage

// File: rtl/demux_route_cnt.sv
// Bank of per-output route counters.
// Each counter wraps at 2^CW and is zeroed by a synchronous clear, which wins over increments.
module demux_route_cnt
  import demux_l1_sched_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr,
  input  logic [NUM_OUTS-1:0]           inc,
  output logic [NUM_OUTS-1:0][CW-1:0]   count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      for (int n = 0; n < NUM_OUTS; n++) begin
        if (inc[n]) count[n] <= count[n] + CW'(1);
      end
    end
  end

endmodule

// File: rtl/demux_l1_sched.sv
// Read scheduler for two upstream FIFOs feeding a 2-in/4-out demux.
// Pops are combinational; valid_lane/selector are delayed one cycle to match FIFO read latency.
module demux_l1_sched
  import demux_l1_sched_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_LANES-1:0] fifo_empty,
  input  logic [NUM_OUTS-1:0]  af,
  input  logic                 clr_counts,
  output logic [NUM_LANES-1:0] pop,
  output logic [NUM_LANES-1:0] valid_lane,
  output logic                 selector,
  output logic [CW-1:0]        count0,
  output logic [CW-1:0]        count1,
  output logic [CW-1:0]        count2,
  output logic [CW-1:0]        count3,
  output logic                 busy
);

  state_t                      state;
  logic                        sel;
  logic [NUM_LANES-1:0]        can_cur;
  logic [NUM_LANES-1:0]        can_oth;
  logic                        any_path;
  logic [NUM_OUTS-1:0]         inc;
  logic [NUM_OUTS-1:0][CW-1:0] counts;

  // A lane can move when it has data and its destination is not almost full.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign can_cur[gi] = ~fifo_empty[gi] & ~af[dest(1'(gi), sel)];
      assign can_oth[gi] = ~fifo_empty[gi] & ~af[dest(1'(gi), ~sel)];
    end
  endgenerate

  assign any_path = |(can_cur | can_oth);
  assign pop      = (state == RUN && enable) ? can_cur : '0;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= 1'b0;
      valid_lane <= '0;
      selector   <= 1'b0;
    end else begin
      valid_lane <= pop;
      selector   <= sel;
      case (state)
        IDLE: begin
          if (enable && fifo_empty != 2'b11) state <= RUN;
        end
        RUN: begin
          if (!enable || fifo_empty == 2'b11) begin
            state <= IDLE;
          end else begin
            if (!any_path) state <= STALL;
            // Flip after a transfer, or early when only the other mapping can move data.
            if (|pop || (can_cur == '0 && can_oth != '0)) sel <= ~sel;
          end
        end
        STALL: begin
          if (!enable)       state <= IDLE;
          else if (any_path) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output n receives lane n/2 when the delayed selector equals n%2.
  generate
    for (genvar gi = 0; gi < NUM_OUTS; gi++) begin : g_inc
      assign inc[gi] = valid_lane[gi / 2] & (selector == ((gi % 2) == 1));
    end
  endgenerate

  generate
    if (DW > 0) begin : g_cnt
      demux_route_cnt #(.CW(CW)) u_route_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_counts),
        .inc   (inc),
        .count (counts)
      );
    end else begin : g_no_cnt
      assign counts = '0;
    end
  endgenerate

  assign count0 = counts[0];
  assign count1 = counts[1];
  assign count2 = counts[2];
  assign count3 = counts[3];

endmodule

// File: tb/tb_demux_l1_sched.sv
// Scoreboard bench for demux_l1_sched: expected transfers are queued at pop time
// and matched against valid_lane/selector one cycle later.
module tb_demux_l1_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] fifo_empty = 2'b11;
  logic [3:0] af = 4'b0000;
  logic       clr_counts = 1'b0;
  logic [1:0] pop;
  logic [1:0] valid_lane;
  logic       selector;
  logic [7:0] count0, count1, count2, count3;
  logic       busy;

  always #5 clk = ~clk;

  demux_l1_sched #(.DW(8), .CW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .af         (af),
    .clr_counts (clr_counts),
    .pop        (pop),
    .valid_lane (valid_lane),
    .selector   (selector),
    .count0     (count0),
    .count1     (count1),
    .count2     (count2),
    .count3     (count3),
    .busy       (busy)
  );

  typedef struct {logic [1:0] lanes; logic sel;} xfer_t;
  typedef enum int {M_IDLE, M_RUN, M_STALL} mst_t;

  xfer_t      sb[$];
  mst_t       mstate;
  bit         msel;
  logic [7:0] mcnt [4];
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int dst(input int lane, input bit s);
    return lane * 2 + (s ? 1 : 0);
  endfunction

  function automatic logic [7:0] dut_cnt(input int n);
    case (n)
      0: return count0;
      1: return count1;
      2: return count2;
      default: return count3;
    endcase
  endfunction

  task automatic mreset();
    mstate = M_IDLE;
    msel   = 1'b0;
    sb.delete();
    for (int n = 0; n < 4; n++) mcnt[n] = 8'd0;
  endtask

  // Inputs are set just after a rising edge; this samples at the falling edge
  // and advances the model to what the next rising edge should produce.
  task automatic tick();
    xfer_t      x;
    logic [1:0] cur, oth, ep;
    logic [7:0] nc [4];
    @(negedge clk);
    for (int n = 0; n < 4; n++) check($sformatf("count%0d", n), dut_cnt(n), mcnt[n]);
    check("busy", busy, mstate != M_IDLE);
    for (int n = 0; n < 4; n++) nc[n] = mcnt[n];
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("valid_lane", valid_lane, x.lanes);
      check("selector", selector, x.sel);
      for (int k = 0; k < 2; k++) if (x.lanes[k]) nc[dst(k, x.sel)] = nc[dst(k, x.sel)] + 8'd1;
    end else begin
      check("valid_idle", valid_lane, 2'b00);
    end
    if (clr_counts) for (int n = 0; n < 4; n++) nc[n] = 8'd0;
    for (int n = 0; n < 4; n++) mcnt[n] = nc[n];
    for (int k = 0; k < 2; k++) begin
      cur[k] = !fifo_empty[k] && !af[dst(k, msel)];
      oth[k] = !fifo_empty[k] && !af[dst(k, !msel)];
    end
    ep = (mstate == M_RUN && enable) ? cur : 2'b00;
    check("pop", pop, ep);
    if (ep != 2'b00) sb.push_back('{ep, msel});
    case (mstate)
      M_IDLE:  if (enable && fifo_empty != 2'b11) mstate = M_RUN;
      M_RUN: begin
        if (!enable || fifo_empty == 2'b11) mstate = M_IDLE;
        else begin
          if ((cur | oth) == 2'b00) mstate = M_STALL;
          if (ep != 2'b00 || (cur == 2'b00 && oth != 2'b00)) msel = !msel;
        end
      end
      default: if (!enable) mstate = M_IDLE; else if ((cur | oth) != 2'b00) mstate = M_RUN;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pop"}, pop, 0);
    check({tag, "_vl"}, valid_lane, 0);
    check({tag, "_sel"}, selector, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cnt"}, {count3, count2, count1, count0}, 0);
  endtask

  initial begin
    mreset();
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Both lanes full-rate: selector alternates, two words per output.
    enable = 1'b1; fifo_empty = 2'b00; af = 4'b0000;
    repeat (5) tick();
    enable = 1'b0; fifo_empty = 2'b11;
    repeat (2) tick();
    check("full_c0", count0, 2);
    check("full_c1", count1, 2);
    check("full_c2", count2, 2);
    check("full_c3", count3, 2);
    clr_counts = 1'b1; tick(); clr_counts = 1'b0; tick();
    check("clr_cnt", {count3, count2, count1, count0}, 0);

    // Lane0 only, output 0 almost full: everything lands on output 1, then wraps.
    enable = 1'b1; fifo_empty = 2'b10; af = 4'b0001;
    for (int i = 0; i < 700 && mcnt[1] != 8'd255; i++) tick();
    check("wrap_pre_c1", count1, 255);
    check("af_c0", count0, 0);
    for (int i = 0; i < 8 && mcnt[1] != 8'd0; i++) tick();
    check("wrap_c1", count1, 0);
    check("wrap_c0", count0, 0);
    check("wrap_c23", {count3, count2}, 0);
    for (int i = 0; i < 4 && sb.size() == 0; i++) tick();
    check("clr_hit_vl", valid_lane, 2'b01);
    clr_counts = 1'b1; tick(); clr_counts = 1'b0;
    enable = 1'b0; fifo_empty = 2'b11;
    repeat (2) tick();
    check("clr_hit_cnt", {count3, count2, count1, count0}, 0);

    // All destinations almost full -> STALL; freeing output 1 resumes lane0.
    enable = 1'b1; fifo_empty = 2'b00; af = 4'b1111;
    repeat (2) tick();
    check("stall_busy", busy, 1);
    check("stall_pop", pop, 0);
    tick();
    af = 4'b1101;
    repeat (6) tick();
    check("resume_c1_nz", count1 != 8'd0, 1);
    check("resume_c0", count0, 0);
    check("resume_c23", {count3, count2}, 0);
    enable = 1'b0; fifo_empty = 2'b11;
    repeat (2) tick();
    clr_counts = 1'b1; tick(); clr_counts = 1'b0;

    // Enable drop in a cycle with both lanes popping.
    enable = 1'b1; fifo_empty = 2'b00; af = 4'b0000;
    repeat (2) tick();
    check("drop_pop_pre", pop, 2'b11);
    enable = 1'b0;
    #1;
    check("drop_pop", pop, 2'b00);
    fifo_empty = 2'b11;
    tick();
    tick();
    check("drop_busy", busy, 0);
    check("drop_lane0", 32'(count0) + 32'(count1), 1);
    check("drop_lane1", 32'(count2) + 32'(count3), 1);

    // Asynchronous reset while a lane0 word is in flight.
    clr_counts = 1'b1; tick(); clr_counts = 1'b0;
    enable = 1'b1; fifo_empty = 2'b10; af = 4'b0000;
    repeat (2) tick();
    check("pre_rst_vl", valid_lane, 2'b01);
    enable = 1'b0; fifo_empty = 2'b11;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    mreset();
    repeat (2) tick();
    check("post_rst_cnt", {count3, count2, count1, count0}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
